// File: rtl/button_pkg.sv
// Shared constants, hold-state encoding and sizing helpers for the button
// input stage.
package button_pkg;

  localparam int CLK_HZ      = 12_000_000;
  localparam int DEBOUNCE_MS = 20;
  localparam int LONG_MS     = 1000;
  localparam int REPEAT_MS   = 250;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG
  } hold_state_e;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  // A zero-valued limit still needs a 1-bit counter to stay legal.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce counter, press/release edge
// pulses and the IDLE/HELD/LONG hold FSM that emits long and repeat pulses.
module button_channel
  import button_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 20,
  parameter int REPEAT_CYCLES   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES);
  localparam logic            PIN_IDLE  = logic'(ACTIVE_LOW != 0);
  localparam logic [DW-1:0]   DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]   LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0]   REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic          r_sync1, r_sync2, r_level, r_press, r_release, r_long, r_repeat;
  logic [DW-1:0] r_db_cnt;
  logic [HW-1:0] r_hold_cnt;
  hold_state_e   r_state;

  logic w_p, w_toggle, w_rise, w_fall;

  assign w_p      = r_sync2 ^ PIN_IDLE;
  assign w_toggle = (w_p != r_level) && (r_db_cnt == DB_LAST);
  assign w_rise   = w_toggle & w_p;
  assign w_fall   = w_toggle & ~w_p;

  // Sync flops reset to the idle pin level so reset exit never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= PIN_IDLE;
      r_sync2   <= PIN_IDLE;
      r_level   <= 1'b0;
      r_db_cnt  <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_press   <= w_rise;
      r_release <= w_fall;
      if (w_p == r_level) begin
        r_db_cnt <= '0;
      end else if (w_toggle) begin
        r_level  <= w_p;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end
  end

  // A release on the same edge as a long/repeat threshold suppresses that pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      if (w_fall) begin
        r_state    <= IDLE;
        r_hold_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rise) begin
              r_state    <= HELD;
              r_hold_cnt <= '0;
            end
          end
          HELD: begin
            if (r_hold_cnt == LONG_LAST) begin
              r_long     <= 1'b1;
              r_state    <= LONG;
              r_hold_cnt <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HW'(1);
            end
          end
          LONG: begin
            if (REPEAT_CYCLES > 0) begin
              if (r_hold_cnt == REP_LAST) begin
                r_repeat   <= 1'b1;
                r_hold_cnt <= '0;
              end else begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
              end
            end
          end
          default: begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_conditioner.sv
// Raw push-button pins in, clean clk-synchronous level and event pulses out;
// one independent button_channel per pin.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
  parameter int LONG_CYCLES     = ms_to_cycles(LONG_MS),
  parameter int REPEAT_CYCLES   = ms_to_cycles(REPEAT_MS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_repeat
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_raw     (btn_raw[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g]),
      .o_long    (btn_long[g]),
      .o_repeat  (btn_repeat[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/long/repeat
// thresholds; every cycle's outputs are compared to hand-derived values.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;
  logic [9:0] w_obs;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTN         (2),
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .REPEAT_CYCLES   (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .btn_repeat  (btn_repeat)
  );

  assign w_obs = {btn_level, btn_press, btn_release, btn_long, btn_repeat};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d: lvl/prs/rel/lng/rep got %b want %b", tag, k, obs, exp);
    end
  endtask

  function automatic logic [9:0] ev(input logic [1:0] l, input logic [1:0] p, input logic [1:0] r,
                                    input logic [1:0] g, input logic [1:0] q);
    return {l, p, r, g, q};
  endfunction

  initial begin
    // 1: pressed during reset, released-and-clean until reset exits
    rst_n   = 1'b0;
    btn_raw = 2'b10;
    tick();
    tick();
    chk("reset_idle", 0, w_obs, 10'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("reset_exit_press", k, w_obs,
          ev({1'b0, k >= 6 && k < 13}, {1'b0, k == 6}, {1'b0, k == 13}, 2'b00, 2'b00));
      if (k == 7) btn_raw[0] = 1'b1;
    end

    // 2: 3-cycle glitch is rejected
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("glitch", k, w_obs, 10'd0);
      if (k == 3) btn_raw[0] = 1'b1;
    end

    // 3: bounce every 2 cycles, then settle pressed
    for (int i = 0; i < 12; i++) begin
      btn_raw[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      chk("bounce", i, w_obs, 10'd0);
    end
    btn_raw[0] = 1'b0;

    // 4: hold through long and repeats, release wins over the repeat at +55
    for (int k = 1; k <= 76; k++) begin
      int j;
      tick();
      j = k - 6;
      chk("hold", j, w_obs,
          ev({1'b0, j >= 0 && j < 55}, {1'b0, j == 0}, {1'b0, j == 55}, {1'b0, j == 20},
             {1'b0, j >= 25 && j <= 50 && (j % 5) == 0}));
      if (j == 49) btn_raw[0] = 1'b1;
    end

    // 5: channel 1 pressed 3 cycles after channel 0
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk("two_ch", k, w_obs,
          ev({k >= 9, k >= 6}, {k == 9, k == 6}, 2'b00, {k == 29, k == 26}, 2'b00));
      if (k == 3) btn_raw[1] = 1'b0;
    end

    // 6: reset while both channels are in LONG; no release, clean re-press
    rst_n = 1'b0;
    #1;
    chk("rst_async", 0, w_obs, 10'd0);
    tick();
    chk("rst_hold", 1, w_obs, 10'd0);
    tick();
    chk("rst_hold", 2, w_obs, 10'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      tick();
      chk("re_press", k, w_obs,
          ev({k >= 6, k >= 6}, {k == 6, k == 6}, 2'b00, {k == 26, k == 26}, 2'b00));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for rainbow_led.
- Takes raw Tang Nano push-button pins (asynchronous, bouncy, active-low) and produces clean, clk-synchronous button events.
- Per button it provides a debounced level plus one-cycle pulses for press, release, long-press and auto-repeat.
- rainbow_led button_a/button_b are driven from btn_press[0]/btn_press[1].

Parameters:
- NUM_BTN, 2, number of independent button channels (>=1).
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- DEBOUNCE_CYCLES, 240_000, consecutive stable cycles required to accept a level change (20 ms at 12 MHz); >=1.
- LONG_CYCLES, 12_000_000, cycles after the press pulse at which the long pulse fires (1 s); must be > 0.
- REPEAT_CYCLES, 3_000_000, auto-repeat period after the long pulse (250 ms); 0 disables repeat.

Ports:
- clk  in  1  system clock, 12 MHz.
- rst_n  in  1  asynchronous active-low reset.
- btn_raw  in  NUM_BTN  raw button pins, asynchronous to clk.
- btn_level  out  NUM_BTN  debounced pressed level, 1 = pressed.
- btn_press  out  NUM_BTN  1-cycle pulse when btn_level rises.
- btn_release  out  NUM_BTN  1-cycle pulse when btn_level falls.
- btn_long  out  NUM_BTN  1-cycle pulse, at most once per press.
- btn_repeat  out  NUM_BTN  1-cycle pulses while held past the long threshold.

Behaviour:
- Reset: asserting rst_n low (asynchronous) clears all outputs and counters.
  - Synchroniser flops reset to the inactive pin level.
  - Debounced state resets to released.
  - No pulse of any kind is generated on reset entry or exit.
- Synchroniser: 2-flop chain per channel. The pressed sample p = sync_out XOR ACTIVE_LOW.
- Debounce, per channel:
  - While p equals btn_level, the debounce counter is held at 0.
  - While p differs, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 with p still differing, btn_level toggles on the next edge and the counter clears.
  - Any sample where p matches btn_level restarts the count from 0.
  - Latency: btn_level changes on the (DEBOUNCE_CYCLES+2)th rising edge after the pin settles.
- Press/release pulses:
  - btn_press is high in exactly the first cycle that btn_level is 1.
  - btn_release is high in exactly the first cycle that btn_level is 0.
- Hold FSM, per channel, with states IDLE, HELD, LONG:
  - IDLE -> HELD on the press pulse; hold counter set to 0.
  - HELD: hold counter increments each cycle. When it reaches LONG_CYCLES, btn_long pulses (the long pulse lands LONG_CYCLES cycles after the press pulse), state -> LONG, counter cleared.
  - LONG, with REPEAT_CYCLES>0: btn_repeat pulses every REPEAT_CYCLES cycles (first pulse at LONG_CYCLES+REPEAT_CYCLES after press). Counter wraps to 0 at each pulse.
  - LONG, with REPEAT_CYCLES=0: counter frozen; no repeat pulses.
  - Any state -> IDLE when btn_level falls. Counters clear and no long/repeat pulse fires in or after the release cycle.
- Counter widths: $clog2(max+1) of the relevant parameter. Counters never wrap outside the rules above.
- Simultaneous events:
  - A release in the same cycle the long threshold would be hit means release wins; no long pulse.
  - Channels are fully independent; any combination of pulses across channels may coincide.
- Glitches shorter than DEBOUNCE_CYCLES produce no output change.
- Mid-operation reset while pressed:
  - Outputs drop immediately; no release pulse.
  - After rst_n rises with the button still held, the press is re-detected after the normal DEBOUNCE_CYCLES+2 latency.

Decomposition:
- Shared package button_pkg holds:
  - CLK_HZ = 12_000_000.
  - ms_to_cycles() constant function.
  - Default DEBOUNCE_MS=20, LONG_MS=1000, REPEAT_MS=250.
  - Hold FSM state enum (IDLE, HELD, LONG).
- One sub-module, button_channel: synchroniser, debounce counter, hold FSM and pulse generation for a single bit.
  - Instantiated NUM_BTN times via generate in button_conditioner.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, ACTIVE_LOW=1.
1. btn_raw[0]=0 (pressed) while rst_n=0 -> all outputs 0. Deassert rst_n -> btn_level[0] rises and btn_press[0] is high for exactly one cycle on the 6th rising edge after deassert.
2. btn_raw[0] low for 3 cycles, then high -> btn_level/btn_press/btn_release stay 0 throughout.
3. btn_raw[0] toggles every 2 cycles for 12 cycles, then stays low -> exactly one btn_press[0], 6 edges after the last transition; no release pulse.
4. Hold btn_raw[0] low for 50 cycles after btn_press, then release:
   - btn_long at press+20.
   - btn_repeat at press+25, +30, +35, +40, +45, +50.
   - One btn_release 6 edges after the pin rises; no repeats afterwards.
5. btn_raw[1] pressed 3 cycles after btn_raw[0] -> btn_press[1] exactly 3 cycles after btn_press[0]; each channel's long pulse is offset by the same 3 cycles.
6. rst_n pulsed low for 2 cycles while channel 0 is in LONG -> all outputs 0 within the reset; no btn_release. After deassert with the pin still low -> new btn_press at +6 edges, btn_long 20 cycles later.
